// File: rtl/obj_alloc_pkg.sv
// Shared types for the object-slot allocator: FSM states and command-priority codes.
package obj_alloc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam logic [2:0] CMD_NONE    = 3'd0;
  localparam logic [2:0] CMD_DEL_ALL = 3'd1;
  localparam logic [2:0] CMD_CRT     = 3'd2;
  localparam logic [2:0] CMD_DEL     = 3'd3;
  localparam logic [2:0] CMD_REF     = 3'd4;

  // del_all always wins; the rest are only taken while the unit is ready
  function automatic logic [2:0] cmd_sel(input logic del_all, input logic crt,
                                         input logic del, input logic rf,
                                         input logic rdy);
    if (del_all)   return CMD_DEL_ALL;
    else if (!rdy) return CMD_NONE;
    else if (crt)  return CMD_CRT;
    else if (del)  return CMD_DEL;
    else if (rf)   return CMD_REF;
    else           return CMD_NONE;
  endfunction

endpackage

// File: rtl/obj_ffs.sv
// Find-first-zero over an N-bit occupancy map; only built with OBJ_ALLOC_FFS_EN.
`ifdef OBJ_ALLOC_FFS_EN
module obj_ffs #(
  parameter int unsigned N = 32,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] map_i,
  output logic [W-1:0] idx_o,
  output logic         none_o
);

  always_comb begin
    idx_o = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (!map_i[i]) idx_o = W'(i);
    end
    none_o = &map_i;
  end

endmodule
`endif

// File: rtl/obj_alloc_unit.sv
// Object-slot allocator: lowest-free-slot create, delete, delete-all and address translation.
// OBJ_ALLOC_FFS_EN selects a single-cycle find-first-zero instead of the iterative SCAN.
module obj_alloc_unit
  import obj_alloc_pkg::*;
#(
  parameter int unsigned NUM_OBJ = 32,
  parameter int unsigned OBJ_W   = $clog2(NUM_OBJ),
  parameter int unsigned CNT_W   = $clog2(NUM_OBJ + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               crt_obj,
  input  logic               del_obj,
  input  logic               del_all,
  input  logic               ref_addr,
  input  logic [OBJ_W-1:0]   obj_num,
  input  logic               changed_in,
  output logic               rdy,
  output logic [OBJ_W-1:0]   addr,
  output logic               addr_vld,
  output logic [OBJ_W-1:0]   lst_stored_obj,
  output logic               lst_stored_obj_vld,
  output logic               obj_mem_full,
  output logic [CNT_W-1:0]   obj_cnt,
  output logic [NUM_OBJ-1:0] obj_map,
  output logic               err,
  output logic               changed_out
);

  localparam logic [OBJ_W-1:0] LAST_IDX  = OBJ_W'(NUM_OBJ - 1);
  localparam logic [OBJ_W:0]   NUM_OBJ_X = (OBJ_W + 1)'(NUM_OBJ);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_OBJ - 1);

  state_e             state_q, state_d;
  logic [OBJ_W-1:0]   nxt_obj_q, nxt_obj_d, nxt_scan;
  logic               full_q, full_d, full_scan;
  logic [NUM_OBJ-1:0] map_q, map_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OBJ_W-1:0]   addr_q, addr_d;
  logic               addr_vld_q, addr_vld_d;
  logic [OBJ_W-1:0]   lst_q, lst_d;
  logic               lst_vld_q, lst_vld_d;
  logic               err_q, err_d;
  logic               changed_q, changed_d;
  logic               obj_ok;

  function automatic logic map_bit(input logic [NUM_OBJ-1:0] m, input logic [OBJ_W-1:0] i);
    logic [NUM_OBJ-1:0] s;
    s = m >> i;
    return s[0];
  endfunction

  function automatic logic [NUM_OBJ-1:0] onehot(input logic [OBJ_W-1:0] i);
    return NUM_OBJ'(1) << i;
  endfunction

  assign obj_ok = ({1'b0, obj_num} < NUM_OBJ_X);

  always_comb begin
    state_d    = state_q;
    nxt_scan   = nxt_obj_q;
    full_scan  = full_q;
    map_d      = map_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    addr_vld_d = 1'b0;
    lst_d      = lst_q;
    lst_vld_d  = 1'b0;
    err_d      = 1'b0;
    changed_d  = changed_in;

    case (cmd_sel(del_all, crt_obj, del_obj, ref_addr, state_q == IDLE))
      CMD_DEL_ALL: begin
        map_d     = '0;
        nxt_scan  = '0;
        cnt_d     = '0;
        full_scan = 1'b0;
        state_d   = IDLE;
      end
      CMD_CRT: begin
        if (full_q) begin
          err_d = 1'b1;
        end else begin
          map_d      = map_q | onehot(nxt_obj_q);
          lst_d      = nxt_obj_q;
          addr_d     = nxt_obj_q;
          lst_vld_d  = 1'b1;
          addr_vld_d = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          if (nxt_obj_q == LAST_IDX || cnt_q == CNT_LAST) begin
            full_scan = 1'b1;
          end else begin
            nxt_scan = nxt_obj_q + OBJ_W'(1);
`ifndef OBJ_ALLOC_FFS_EN
            state_d  = SCAN;
`endif
          end
        end
      end
      CMD_DEL: begin
        if (obj_ok && map_bit(map_q, obj_num)) begin
          map_d     = map_q & ~onehot(obj_num);
          cnt_d     = cnt_q - CNT_W'(1);
          full_scan = 1'b0;
          // while full, nxt_obj is stale, so the freed slot is the only free one
          if (full_q || obj_num < nxt_obj_q) nxt_scan = obj_num;
        end else begin
          err_d = 1'b1;
        end
      end
      CMD_REF: begin
        if (obj_ok) begin
          addr_d     = obj_num;
          addr_vld_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: begin
        if (state_q == SCAN) begin
          if (!map_bit(map_q, nxt_obj_q)) begin
            state_d = IDLE;
          end else if (nxt_obj_q == LAST_IDX) begin
            full_scan = 1'b1;
            state_d   = IDLE;
          end else begin
            nxt_scan = nxt_obj_q + OBJ_W'(1);
          end
        end
      end
    endcase
  end

`ifdef OBJ_ALLOC_FFS_EN
  logic [OBJ_W-1:0] ffs_idx;
  logic             ffs_none;

  obj_ffs #(.N(NUM_OBJ), .W(OBJ_W)) u_ffs (
    .map_i (map_d),
    .idx_o (ffs_idx),
    .none_o(ffs_none)
  );

  assign nxt_obj_d = ffs_idx;
  assign full_d    = ffs_none;
`else
  assign nxt_obj_d = nxt_scan;
  assign full_d    = full_scan;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      nxt_obj_q  <= '0;
      full_q     <= 1'b0;
      map_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      addr_vld_q <= 1'b0;
      lst_q      <= '0;
      lst_vld_q  <= 1'b0;
      err_q      <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      nxt_obj_q  <= nxt_obj_d;
      full_q     <= full_d;
      map_q      <= map_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      addr_vld_q <= addr_vld_d;
      lst_q      <= lst_d;
      lst_vld_q  <= lst_vld_d;
      err_q      <= err_d;
      changed_q  <= changed_d;
    end
  end

  assign rdy                = (state_q == IDLE);
  assign addr               = addr_q;
  assign addr_vld           = addr_vld_q;
  assign lst_stored_obj     = lst_q;
  assign lst_stored_obj_vld = lst_vld_q;
  assign obj_mem_full       = full_q;
  assign obj_cnt            = cnt_q;
  assign obj_map            = map_q;
  assign err                = err_q;
  assign changed_out        = changed_q;

endmodule

// File: tb/tb_obj_alloc_unit.sv
// Directed table-driven bench for obj_alloc_unit with 8 slots and a 4-bit obj_num.
module tb_obj_alloc_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       crt_obj, del_obj, del_all, ref_addr, changed_in;
  logic [3:0] obj_num;
  logic       rdy, addr_vld, lst_stored_obj_vld, obj_mem_full, err, changed_out;
  logic [3:0] addr, lst_stored_obj, obj_cnt;
  logic [7:0] obj_map;

  always #5 clk = ~clk;

  obj_alloc_unit #(.NUM_OBJ(8), .OBJ_W(4), .CNT_W(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .crt_obj           (crt_obj),
    .del_obj           (del_obj),
    .del_all           (del_all),
    .ref_addr          (ref_addr),
    .obj_num           (obj_num),
    .changed_in        (changed_in),
    .rdy               (rdy),
    .addr              (addr),
    .addr_vld          (addr_vld),
    .lst_stored_obj    (lst_stored_obj),
    .lst_stored_obj_vld(lst_stored_obj_vld),
    .obj_mem_full      (obj_mem_full),
    .obj_cnt           (obj_cnt),
    .obj_map           (obj_map),
    .err               (err),
    .changed_out       (changed_out)
  );

  typedef struct packed {
    logic       rdy;
    logic [3:0] addr;
    logic       av;
    logic [3:0] lst;
    logic       lv;
    logic       full;
    logic [3:0] cnt;
    logic [7:0] map;
    logic       err;
    logic       cho;
  } out_t;

  typedef struct packed {
    logic       crt, del, dall, rf;
    logic [3:0] num;
    logic       chg;
    out_t       exp;
  } vec_t;

  int   n_pass  = 0;
  int   n_total = 0;
  vec_t tbl[$];

  function automatic vec_t mk(input logic c, input logic d, input logic a, input logic r,
                              input logic [3:0] n, input logic ch,
                              input logic rd, input logic [3:0] ad, input logic av,
                              input logic [3:0] ls, input logic lv, input logic fu,
                              input logic [3:0] cn, input logic [7:0] mp,
                              input logic er, input logic co);
    vec_t t;
    t.crt = c; t.del = d; t.dall = a; t.rf = r; t.num = n; t.chg = ch;
    t.exp = '{rdy: rd, addr: ad, av: av, lst: ls, lv: lv, full: fu, cnt: cn,
              map: mp, err: er, cho: co};
    return t;
  endfunction

  function automatic out_t mk_out(input logic rd, input logic [3:0] ad, input logic av,
                                  input logic [3:0] ls, input logic lv, input logic fu,
                                  input logic [3:0] cn, input logic [7:0] mp,
                                  input logic er, input logic co);
    out_t o;
    o = '{rdy: rd, addr: ad, av: av, lst: ls, lv: lv, full: fu, cnt: cn,
          map: mp, err: er, cho: co};
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = '{rdy: rdy, addr: addr, av: addr_vld, lst: lst_stored_obj, lv: lst_stored_obj_vld,
            full: obj_mem_full, cnt: obj_cnt, map: obj_map, err: err, cho: changed_out};
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got rdy=%b addr=%0d av=%b lst=%0d lv=%b full=%b cnt=%0d map=%h err=%b cho=%b ; required rdy=%b addr=%0d av=%b lst=%0d lv=%b full=%b cnt=%0d map=%h err=%b cho=%b",
               name, act.rdy, act.addr, act.av, act.lst, act.lv, act.full, act.cnt, act.map,
               act.err, act.cho, exp.rdy, exp.addr, exp.av, exp.lst, exp.lv, exp.full,
               exp.cnt, exp.map, exp.err, exp.cho);
    end
  endtask

  task automatic drive(input logic c, input logic d, input logic a, input logic r,
                       input logic [3:0] n, input logic ch);
    crt_obj = c; del_obj = d; del_all = a; ref_addr = r; obj_num = n; changed_in = ch;
  endtask

  initial begin
    //           c d a r num ch | rdy addr av lst lv full cnt map   err cho
    // fill slots 0..7, rdy low one cycle after each create, 9th create rejected
    tbl.push_back(mk(1,0,0,0,4'd0,0, 0,4'd0,1,4'd0,1,0,4'd1,8'h01,0,0));
    tbl.push_back(mk(0,0,0,0,4'd0,1, 1,4'd0,0,4'd0,0,0,4'd1,8'h01,0,1));
    tbl.push_back(mk(1,0,0,0,4'd0,0, 0,4'd1,1,4'd1,1,0,4'd2,8'h03,0,0));
    tbl.push_back(mk(0,0,0,0,4'd0,0, 1,4'd1,0,4'd1,0,0,4'd2,8'h03,0,0));
    tbl.push_back(mk(1,0,0,0,4'd0,0, 0,4'd2,1,4'd2,1,0,4'd3,8'h07,0,0));
    tbl.push_back(mk(0,0,0,0,4'd0,0, 1,4'd2,0,4'd2,0,0,4'd3,8'h07,0,0));
    tbl.push_back(mk(1,0,0,0,4'd0,0, 0,4'd3,1,4'd3,1,0,4'd4,8'h0F,0,0));
    tbl.push_back(mk(0,0,0,0,4'd0,0, 1,4'd3,0,4'd3,0,0,4'd4,8'h0F,0,0));
    tbl.push_back(mk(1,0,0,0,4'd0,0, 0,4'd4,1,4'd4,1,0,4'd5,8'h1F,0,0));
    tbl.push_back(mk(0,0,0,0,4'd0,0, 1,4'd4,0,4'd4,0,0,4'd5,8'h1F,0,0));
    tbl.push_back(mk(1,0,0,0,4'd0,0, 0,4'd5,1,4'd5,1,0,4'd6,8'h3F,0,0));
    tbl.push_back(mk(0,0,0,0,4'd0,0, 1,4'd5,0,4'd5,0,0,4'd6,8'h3F,0,0));
    tbl.push_back(mk(1,0,0,0,4'd0,0, 0,4'd6,1,4'd6,1,0,4'd7,8'h7F,0,0));
    tbl.push_back(mk(0,0,0,0,4'd0,0, 1,4'd6,0,4'd6,0,0,4'd7,8'h7F,0,0));
    tbl.push_back(mk(1,0,0,0,4'd0,0, 1,4'd7,1,4'd7,1,1,4'd8,8'hFF,0,0));
    tbl.push_back(mk(1,0,0,0,4'd0,0, 1,4'd7,0,4'd7,0,1,4'd8,8'hFF,1,0));
    // delete 5 from full map, re-create takes 5 and fills again
    tbl.push_back(mk(0,1,0,0,4'd5,0, 1,4'd7,0,4'd7,0,0,4'd7,8'hDF,0,0));
    tbl.push_back(mk(1,0,0,0,4'd0,0, 1,4'd5,1,4'd5,1,1,4'd8,8'hFF,0,0));
    tbl.push_back(mk(0,0,1,0,4'd0,0, 1,4'd5,0,4'd5,0,0,4'd0,8'h00,0,0));
    // build map 0F
    tbl.push_back(mk(1,0,0,0,4'd0,0, 0,4'd0,1,4'd0,1,0,4'd1,8'h01,0,0));
    tbl.push_back(mk(0,0,0,0,4'd0,0, 1,4'd0,0,4'd0,0,0,4'd1,8'h01,0,0));
    tbl.push_back(mk(1,0,0,0,4'd0,0, 0,4'd1,1,4'd1,1,0,4'd2,8'h03,0,0));
    tbl.push_back(mk(0,0,0,0,4'd0,0, 1,4'd1,0,4'd1,0,0,4'd2,8'h03,0,0));
    tbl.push_back(mk(1,0,0,0,4'd0,0, 0,4'd2,1,4'd2,1,0,4'd3,8'h07,0,0));
    tbl.push_back(mk(0,0,0,0,4'd0,0, 1,4'd2,0,4'd2,0,0,4'd3,8'h07,0,0));
    tbl.push_back(mk(1,0,0,0,4'd0,0, 0,4'd3,1,4'd3,1,0,4'd4,8'h0F,0,0));
    tbl.push_back(mk(0,0,0,0,4'd0,0, 1,4'd3,0,4'd3,0,0,4'd4,8'h0F,0,0));
    // del 1, create gives 1 then scans 2,3,4 (3 cycles not ready), next create gives 4
    tbl.push_back(mk(0,1,0,0,4'd1,0, 1,4'd3,0,4'd3,0,0,4'd3,8'h0D,0,0));
    tbl.push_back(mk(1,0,0,0,4'd0,0, 0,4'd1,1,4'd1,1,0,4'd4,8'h0F,0,0));
    tbl.push_back(mk(0,0,0,0,4'd0,0, 0,4'd1,0,4'd1,0,0,4'd4,8'h0F,0,0));
    tbl.push_back(mk(0,0,0,0,4'd0,0, 0,4'd1,0,4'd1,0,0,4'd4,8'h0F,0,0));
    tbl.push_back(mk(0,0,0,0,4'd0,0, 1,4'd1,0,4'd1,0,0,4'd4,8'h0F,0,0));
    tbl.push_back(mk(1,0,0,0,4'd0,0, 0,4'd4,1,4'd4,1,0,4'd5,8'h1F,0,0));
    // create while not ready is dropped; changed passes through during SCAN
    tbl.push_back(mk(1,0,0,0,4'd0,1, 1,4'd4,0,4'd4,0,0,4'd5,8'h1F,0,1));
    // del_all aborts a SCAN
    tbl.push_back(mk(0,1,0,0,4'd0,0, 1,4'd4,0,4'd4,0,0,4'd4,8'h1E,0,0));
    tbl.push_back(mk(1,0,0,0,4'd0,0, 0,4'd0,1,4'd0,1,0,4'd5,8'h1F,0,0));
    tbl.push_back(mk(0,0,1,0,4'd0,0, 1,4'd0,0,4'd0,0,0,4'd0,8'h00,0,0));
    tbl.push_back(mk(1,0,0,0,4'd0,0, 0,4'd0,1,4'd0,1,0,4'd1,8'h01,0,0));
    tbl.push_back(mk(0,0,0,0,4'd0,0, 1,4'd0,0,4'd0,0,0,4'd1,8'h01,0,0));
    // error cases and ref without occupancy check
    tbl.push_back(mk(0,1,0,0,4'd6,0, 1,4'd0,0,4'd0,0,0,4'd1,8'h01,1,0));
    tbl.push_back(mk(0,0,0,1,4'd9,0, 1,4'd0,0,4'd0,0,0,4'd1,8'h01,1,0));
    tbl.push_back(mk(0,0,0,1,4'd6,0, 1,4'd6,1,4'd0,0,0,4'd1,8'h01,0,0));
    tbl.push_back(mk(0,1,0,0,4'd9,0, 1,4'd6,0,4'd0,0,0,4'd1,8'h01,1,0));
    // priority: crt over del, del_all over crt, del over ref
    tbl.push_back(mk(1,1,0,0,4'd0,0, 0,4'd1,1,4'd1,1,0,4'd2,8'h03,0,0));
    tbl.push_back(mk(0,0,0,0,4'd0,0, 1,4'd1,0,4'd1,0,0,4'd2,8'h03,0,0));
    tbl.push_back(mk(1,0,1,0,4'd0,0, 1,4'd1,0,4'd1,0,0,4'd0,8'h00,0,0));
    tbl.push_back(mk(0,1,0,1,4'd3,0, 1,4'd1,0,4'd1,0,0,4'd0,8'h00,1,0));

    rst_n = 1'b0;
    drive(0,0,0,0,4'd0,1);
    repeat (2) @(posedge clk);
    #1;
    check("reset", mk_out(1,4'd0,0,4'd0,0,0,4'd0,8'h00,0,0));
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].crt, tbl[i].del, tbl[i].dall, tbl[i].rf, tbl[i].num, tbl[i].chg);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // reset while scanning returns everything to reset values
    drive(1,0,0,0,4'd0,0);
    @(posedge clk);
    #1;
    check("pre_rst_crt", mk_out(0,4'd0,1,4'd0,1,0,4'd1,8'h01,0,0));
    drive(0,0,0,0,4'd0,1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_scan", mk_out(1,4'd0,0,4'd0,0,0,4'd0,8'h00,0,0));
    rst_n = 1'b1;
    drive(0,0,0,0,4'd0,0);
    @(posedge clk);
    #1;
    check("post_rst_idle", mk_out(1,4'd0,0,4'd0,0,0,4'd0,8'h00,0,0));
    drive(1,0,0,0,4'd0,0);
    @(posedge clk);
    #1;
    check("post_rst_crt", mk_out(0,4'd0,1,4'd0,1,0,4'd1,8'h01,0,0));
    drive(0,0,0,0,4'd0,0);
    @(posedge clk);
    #1;
    check("post_rst_scan", mk_out(1,4'd0,0,4'd0,0,0,4'd1,8'h01,0,0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/obj_alloc_unit.md
# obj_alloc_unit

Parametrised object-slot allocator; successor to the fixed 32-slot object unit. Tracks occupancy of `NUM_OBJ` object slots in video memory, hands out the lowest free slot on create, frees slots on delete/delete-all, and translates object numbers into video-memory addresses. Sits between matrix_unit (commands), video_memory_unit (address), clipping logic (occupancy map) and framebuffer/rasterizer (`changed` flag). Adds a ready handshake, a live-object count, an error pulse and an optional single-cycle free-slot search.

## Interface
- `NUM_OBJ`, 32, number of object slots (2..256, need not be a power of 2)
- `OBJ_W`, `$clog2(NUM_OBJ)`, slot index width
- `CNT_W`, `$clog2(NUM_OBJ+1)`, live-count width
- `clk` in 1 — single clock, all state on rising edge
- `rst_n` in 1 — reset is synchronous and active-low
- `crt_obj` in 1 — create pulse; honoured only when `rdy`
- `del_obj` in 1 — delete `obj_num`; honoured only when `rdy`
- `del_all` in 1 — clear all slots; honoured in any state
- `ref_addr` in 1 — translate `obj_num` to `addr`; honoured only when `rdy`
- `obj_num` in OBJ_W — target slot for delete/ref
- `changed_in` in 1 — scene-changed flag from matrix_unit
- `rdy` out 1 — unit accepts crt/del/ref this cycle
- `addr` out OBJ_W — video-memory slot address
- `addr_vld` out 1 — one-cycle pulse, `addr` updated
- `lst_stored_obj` out OBJ_W — slot given to last create
- `lst_stored_obj_vld` out 1 — one-cycle pulse with create result
- `obj_mem_full` out 1 — all slots occupied
- `obj_cnt` out CNT_W — number of occupied slots
- `obj_map` out NUM_OBJ — occupancy bitmap, bit i = slot i live
- `err` out 1 — one-cycle pulse, command rejected
- `changed_out` out 1 — `changed_in` delayed one cycle

## Operation
- Invariant: internal `nxt_obj` is always the lowest free index unless `obj_mem_full`.
- States: IDLE, SCAN. `rdy` = (state==IDLE). Commands other than `del_all` while `!rdy` are ignored (not queued).
- Priority in one cycle: `del_all` > `crt_obj` > `del_obj` > `ref_addr`; lower ones dropped.
- Create (IDLE, not full): set `obj_map[nxt_obj]`, `lst_stored_obj`=`addr`=`nxt_obj`, pulse `lst_stored_obj_vld` and `addr_vld`, `obj_cnt`+1. If `nxt_obj`==NUM_OBJ-1 or count reaches NUM_OBJ: set full, stay IDLE; else `nxt_obj`+1, go SCAN.
- SCAN: each cycle test `obj_map[nxt_obj]`; free → IDLE; occupied and index NUM_OBJ-1 → set full, IDLE; else increment and stay.
- Create while full: no state change, pulse `err`.
- Delete: `obj_num` occupied → clear bit, `obj_cnt`-1, clear full, `nxt_obj`=min(`nxt_obj`,`obj_num`) (=`obj_num` if was full). `obj_num` free or ≥NUM_OBJ → pulse `err`, no change.
- Ref: `addr`=`obj_num`, pulse `addr_vld`; `obj_num`≥NUM_OBJ → `err`, no pulse. Occupancy not checked.
- Delete-all: map=0, `nxt_obj`=0, count=0, full=0, state→IDLE (aborts SCAN); `addr` holds, no pulses.

## Timing
- Reset values: `addr`=0, `lst_stored_obj`=0, all valid/err pulses 0, `obj_mem_full`=0, `obj_cnt`=0, `obj_map`=0, `changed_out`=0, state IDLE (`rdy`=1).
- Command sampled at edge t; all outputs reflect it after edge t (visible cycle t+1). Pulses last exactly one cycle.
- Create latency to `addr_vld`: 1 cycle. `rdy` low for k cycles after create, k = distance from allocated slot to next free slot (1..NUM_OBJ-1).
- `changed_out` latency 1 cycle, independent of state.
- Reset mid-SCAN: everything returns to reset values next edge.

## Configuration
- `OBJ_ALLOC_FFS_EN` defined: next free slot computed combinationally by find-first-zero over the post-update map; SCAN never entered, `rdy` constant 1 outside reset, create-to-create back-to-back every cycle.
- Undefined: iterative SCAN as above (smaller area).
- All other behaviour, including `err` and full handling, identical.

## Structure
- `obj_alloc_pkg`: state enum (IDLE, SCAN), command-priority encoding localparams.
- Sub-module `obj_ffs` (parametrised find-first-zero, returns index + `none` flag); instantiated only under `OBJ_ALLOC_FFS_EN`.

## Test plan
- NUM_OBJ=8, reset, crt → `lst_stored_obj`=0, `addr`=0, `addr_vld` pulse, `obj_cnt`=1, `obj_map`=8'h01, `rdy` low 1 cycle.
- 8 creates → slots 0..7, `obj_mem_full`=1 after 8th; 9th crt → `err` pulse, map stays 8'hFF.
- Full map, del 5 → map 8'hDF, full=0, cnt=7; crt → slot 5, full=1 again.
- Map 8'h0F after del 1: crt gives 1, then SCAN 3 cycles (2,3,4), next crt gives 4.
- del_all issued mid-SCAN → map=0, cnt=0, `rdy`=1 next cycle; next crt gives slot 0.
- del on free slot 6 and ref 9 with NUM_OBJ=8 → `err` each, no `addr_vld`; `changed_in` pulse appears on `changed_out` one cycle later.
